// File: rtl/amiga_port_responder.sv
// amiga_port_responder
// Bus target for the 68040 card's dynamic bus sizing logic. Accepts a transfer
// on nTS, runs a wait-state-counted access to a local 32-bit device, and
// terminates with DSACK coded for a 32- or 16-bit port. On a 16-bit port,
// byte lanes are steered so that the initiator's word retry at A=10 reaches
// the low half of the device.
module amiga_port_responder #(
    parameter int PORT_WIDTH  = 32,   // 32 or 16
    parameter int WAIT_STATES = 2,    // 1..15
    parameter int TIMEOUT     = 255   // 0..255
) (
    input  logic        CLK40,
    input  logic        RESET,
    input  logic        nTS,
    input  logic        RnW,
    input  logic [1:0]  A,
    input  logic [1:0]  SIZ,
    input  logic        DEV_SEL,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    output logic [1:0]  DSACK,
    output logic        DEV_RD,
    output logic        DEV_WR,
    output logic [3:0]  DEV_BE,
    output logic [31:0] DEV_WDATA,
    input  logic [31:0] DEV_RDATA,
    input  logic        DEV_READY,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam bit          IS_16      = (PORT_WIDTH == 16);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [7:0]  TO_INIT    = 8'(TIMEOUT);
    localparam logic [1:0]  DSACK_DONE = IS_16 ? 2'b01 : 2'b00;
    localparam logic [1:0]  DSACK_WAIT = 2'b11;
    localparam logic [31:0] BUS_IDLE   = 32'hFFFF_FFFF;

    // Byte enables for the latched size/address. A 16-bit port only ever
    // serves the first half of a long; the initiator retries the rest at A=10.
    function automatic logic [3:0] calc_be(input logic [1:0] addr, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b01:   be = 4'b1000 >> addr;
            2'b10:   be = addr[0] ? 4'b0000 : (addr[1] ? 4'b0011 : 4'b1100);
            default: be = IS_16 ? 4'b1100 : 4'b1111;
        endcase
        return be;
    endfunction

    // Device read data as seen on the bus. A 16-bit port always answers on
    // D[31:16]; A[1] picks which device half feeds those lanes.
    function automatic logic [31:0] map_rdata(input logic [31:0] rdata, input logic a1);
        logic [31:0] d;
        if (IS_16) begin
            d = {(a1 ? rdata[15:0] : rdata[31:16]), 16'hFFFF};
        end else begin
            d = rdata;
        end
        return d;
    endfunction

    // Bus write data as presented to the device. A 16-bit initiator only
    // drives D[31:16], so that half is offered to both device halves and the
    // byte enables pick the lanes that actually get written.
    function automatic logic [31:0] map_wdata(input logic [31:0] din);
        logic [31:0] w;
        if (IS_16) begin
            w = {din[31:16], din[31:16]};
        end else begin
            w = din;
        end
        return w;
    endfunction

    state_t      state_q, state_d;
    logic        rnw_q, rnw_d;
    logic        a1_q, a1_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        first_q, first_d;
    logic        dev_rd_q, dev_rd_d;
    logic        dev_wr_q, dev_wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    logic        terr_q, terr_d;

    // Next-state and next-register values for the whole transfer sequence.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        rnw_d      = rnw_q;
        a1_d       = a1_q;
        be_d       = be_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        first_d    = 1'b0;
        dev_rd_d   = 1'b0;
        dev_wr_d   = 1'b0;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        terr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!nTS && DEV_SEL) begin
                    state_d    = S_WAIT;
                    rnw_d      = RnW;
                    a1_d       = A[1];
                    be_d       = calc_be(A, SIZ);
                    wait_cnt_d = WAIT_INIT;
                    to_cnt_d   = TO_INIT;
                    first_d    = 1'b1;
                end
            end

            S_WAIT: begin
                // Write data is taken one edge after nTS and held for the cycle.
                if (first_q) begin
                    wdata_d = map_wdata(D_IN);
                end

                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (DEV_READY) begin
                    state_d = S_ACK;
                    dout_d  = (be_q == 4'b0000) ? BUS_IDLE : map_rdata(DEV_RDATA, a1_q);
                end else if (to_cnt_q != 8'd0) begin
                    to_cnt_d = to_cnt_q - 8'd1;
                end else begin
                    state_d = S_ACK;
                    dout_d  = BUS_IDLE;
                    terr_d  = 1'b1;
                end

                // Strobes run only while the cycle stays in WAIT; a misaligned
                // access (no lanes enabled) never touches the device.
                if (state_d == S_WAIT && be_q != 4'b0000) begin
                    dev_rd_d = rnw_q;
                    dev_wr_d = !rnw_q;
                end
            end

            S_ACK: begin
                state_d = S_RECOVER;
                be_d    = 4'b0000;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK40) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q    <= S_IDLE;
            rnw_q      <= 1'b1;
            a1_q       <= 1'b0;
            be_q       <= 4'b0000;
            wait_cnt_q <= 4'd0;
            to_cnt_q   <= 8'd0;
            first_q    <= 1'b0;
            dev_rd_q   <= 1'b0;
            dev_wr_q   <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            dout_q     <= BUS_IDLE;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnw_q      <= rnw_d;
            a1_q       <= a1_d;
            be_q       <= be_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            first_q    <= first_d;
            dev_rd_q   <= dev_rd_d;
            dev_wr_q   <= dev_wr_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            terr_q     <= terr_d;
        end
    end

    assign DSACK       = (state_q == S_ACK) ? DSACK_DONE : DSACK_WAIT;
    assign D_OE        = (state_q == S_ACK) && rnw_q;
    assign D_OUT       = dout_q;
    assign DEV_RD      = dev_rd_q;
    assign DEV_WR      = dev_wr_q;
    assign DEV_BE      = be_q;
    assign DEV_WDATA   = wdata_q;
    assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_amiga_port_responder.sv
// Scoreboard bench for amiga_port_responder. Three instances share the bus
// inputs and are selected by their own DEV_SEL: a 32-bit port (N=2), a
// 16-bit port (N=2) and a 32-bit port with N=1 and a short timeout.
module tb_amiga_port_responder;

    typedef struct {
        logic [1:0]  dsack;
        logic        chk_dout;
        logic [31:0] dout;
        logic        doe;
        logic        terr;
        int          ack_cyc;
        logic [3:0]  be;
        int          rd_n;
        int          wr_n;
        logic [31:0] wdata;
        logic [31:0] wmask;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        n_ts;
    logic        rnw;
    logic [1:0]  a;
    logic [1:0]  siz;
    logic [2:0]  dev_sel;
    logic [31:0] d_in;
    logic [31:0] dev_rdata;
    logic        dev_ready;

    logic [31:0] d_out     [3];
    logic        d_oe      [3];
    logic [1:0]  dsack     [3];
    logic        dev_rd    [3];
    logic        dev_wr    [3];
    logic [3:0]  dev_be    [3];
    logic [31:0] dev_wdata [3];
    logic        terr      [3];

    exp_t sb_q [3][$];
    int   done   [3];
    int   pushed [3];
    int   rd_n   [3];
    int   wr_n   [3];
    int   terr_seen [3];
    int   oe_viol   [3];
    int   cyc;
    int   n_total;
    int   n_pass;

    amiga_port_responder #(.PORT_WIDTH(32), .WAIT_STATES(2), .TIMEOUT(255)) dut0 (
        .CLK40(clk), .RESET(rst), .nTS(n_ts), .RnW(rnw), .A(a), .SIZ(siz),
        .DEV_SEL(dev_sel[0]), .D_IN(d_in), .D_OUT(d_out[0]), .D_OE(d_oe[0]),
        .DSACK(dsack[0]), .DEV_RD(dev_rd[0]), .DEV_WR(dev_wr[0]), .DEV_BE(dev_be[0]),
        .DEV_WDATA(dev_wdata[0]), .DEV_RDATA(dev_rdata), .DEV_READY(dev_ready),
        .TIMEOUT_ERR(terr[0])
    );

    amiga_port_responder #(.PORT_WIDTH(16), .WAIT_STATES(2), .TIMEOUT(255)) dut1 (
        .CLK40(clk), .RESET(rst), .nTS(n_ts), .RnW(rnw), .A(a), .SIZ(siz),
        .DEV_SEL(dev_sel[1]), .D_IN(d_in), .D_OUT(d_out[1]), .D_OE(d_oe[1]),
        .DSACK(dsack[1]), .DEV_RD(dev_rd[1]), .DEV_WR(dev_wr[1]), .DEV_BE(dev_be[1]),
        .DEV_WDATA(dev_wdata[1]), .DEV_RDATA(dev_rdata), .DEV_READY(dev_ready),
        .TIMEOUT_ERR(terr[1])
    );

    amiga_port_responder #(.PORT_WIDTH(32), .WAIT_STATES(1), .TIMEOUT(4)) dut2 (
        .CLK40(clk), .RESET(rst), .nTS(n_ts), .RnW(rnw), .A(a), .SIZ(siz),
        .DEV_SEL(dev_sel[2]), .D_IN(d_in), .D_OUT(d_out[2]), .D_OE(d_oe[2]),
        .DSACK(dsack[2]), .DEV_RD(dev_rd[2]), .DEV_WR(dev_wr[2]), .DEV_BE(dev_be[2]),
        .DEV_WDATA(dev_wdata[2]), .DEV_RDATA(dev_rdata), .DEV_READY(dev_ready),
        .TIMEOUT_ERR(terr[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ds, input logic chk, input logic [31:0] dout,
                                input logic oe, input logic te, input logic [3:0] be,
                                input int rdn, input int wrn, input logic [31:0] wd,
                                input logic [31:0] wm);
        exp_t e;
        e.dsack    = ds;
        e.chk_dout = chk;
        e.dout     = dout;
        e.doe      = oe;
        e.terr     = te;
        e.ack_cyc  = 0;
        e.be       = be;
        e.rd_n     = rdn;
        e.wr_n     = wrn;
        e.wdata    = wd;
        e.wmask    = wm;
        return e;
    endfunction

    // Monitor: on every DSACK assertion pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    rd_n[i] = 0;
                    wr_n[i] = 0;
                end else begin
                    if (dev_rd[i]) rd_n[i]++;
                    if (dev_wr[i]) wr_n[i]++;
                    if (terr[i]) terr_seen[i]++;
                    if (dsack[i] == 2'b11 && d_oe[i]) oe_viol[i]++;
                    if (dsack[i] != 2'b11) begin
                        done[i]++;
                        check($sformatf("du%0d_ack_count", i), done[i], pushed[i]);
                        if (sb_q[i].size() != 0) begin
                            e = sb_q[i].pop_front();
                            check($sformatf("du%0d_dsack", i), {30'd0, dsack[i]}, {30'd0, e.dsack});
                            check($sformatf("du%0d_ack_cycle", i), cyc, e.ack_cyc);
                            check($sformatf("du%0d_d_oe", i), {31'd0, d_oe[i]}, {31'd0, e.doe});
                            check($sformatf("du%0d_timeout_err", i), {31'd0, terr[i]}, {31'd0, e.terr});
                            check($sformatf("du%0d_dev_be", i), {28'd0, dev_be[i]}, {28'd0, e.be});
                            check($sformatf("du%0d_rd_clocks", i), rd_n[i], e.rd_n);
                            check($sformatf("du%0d_wr_clocks", i), wr_n[i], e.wr_n);
                            if (e.chk_dout)
                                check($sformatf("du%0d_d_out", i), d_out[i], e.dout);
                            if (e.wmask != 32'd0)
                                check($sformatf("du%0d_dev_wdata", i), dev_wdata[i] & e.wmask, e.wdata);
                        end
                        rd_n[i] = 0;
                        wr_n[i] = 0;
                    end
                end
            end
        end
    end

    // Issue one accepted transfer, push its expectation, wait for its ACK.
    // Called at posedge+1; lat is the number of edges from nTS sample to ACK.
    task automatic run_cycle(input int idx, input logic rnw_i, input logic [1:0] a_i,
                             input logic [1:0] siz_i, input logic [31:0] din,
                             input logic [31:0] rdata, input logic rdy, input int lat,
                             input exp_t e_in);
        exp_t e;
        int   target;
        int   t;
        e         = e_in;
        rnw       = rnw_i;
        a         = a_i;
        siz       = siz_i;
        d_in      = din;
        dev_rdata = rdata;
        dev_ready = rdy;
        dev_sel   = 3'b000;
        dev_sel[idx] = 1'b1;
        n_ts      = 1'b0;
        e.ack_cyc = cyc + 1 + lat;
        sb_q[idx].push_back(e);
        pushed[idx]++;
        target = done[idx] + 1;
        @(posedge clk); #1;
        n_ts    = 1'b1;
        dev_sel = 3'b000;
        t = 0;
        while (done[idx] < target && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (done[idx] < target)
            check($sformatf("du%0d_ack_wait", idx), done[idx], target);
        @(posedge clk); #1;
        dev_ready = 1'b1;
    endtask

    initial begin
        int target;
        n_total = 0;
        n_pass  = 0;
        for (int i = 0; i < 3; i++) begin
            done[i] = 0; pushed[i] = 0; rd_n[i] = 0; wr_n[i] = 0;
            terr_seen[i] = 0; oe_viol[i] = 0;
        end
        rst = 1'b1; n_ts = 1'b1; rnw = 1'b1; a = 2'b00; siz = 2'b00;
        dev_sel = 3'b000; d_in = 32'd0; dev_rdata = 32'd0; dev_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_dsack",  {30'd0, dsack[0]}, 32'd3);
        check("rst_d_oe",   {31'd0, d_oe[0]}, 32'd0);
        check("rst_dev_rd", {31'd0, dev_rd[0]}, 32'd0);
        check("rst_dev_wr", {31'd0, dev_wr[0]}, 32'd0);
        check("rst_terr",   {31'd0, terr[0]}, 32'd0);
        check("rst_dev_be", {28'd0, dev_be[0]}, 32'd0);
        check("rst_wdata",  dev_wdata[0], 32'h0000_0000);
        check("rst_d_out",  d_out[0], 32'hFFFF_FFFF);
        check("rst_du1_dsack", {30'd0, dsack[1]}, 32'd3);
        check("rst_du1_d_out", d_out[1], 32'hFFFF_FFFF);
        check("rst_du2_dsack", {30'd0, dsack[2]}, 32'd3);
        check("rst_du2_d_out", d_out[2], 32'hFFFF_FFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        // 32-bit port, N=2: ACK at k+3, strobe for 2 clocks.
        run_cycle(0, 1'b1, 2'b00, 2'b00, 32'h0, 32'h1234_5678, 1'b1, 3,
                  mk(2'b00, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 4'b1111, 2, 0, 32'h0, 32'h0));
        run_cycle(0, 1'b0, 2'b01, 2'b01, 32'h00AB_0000, 32'hDEAD_BEEF, 1'b1, 3,
                  mk(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 0, 2, 32'h00AB_0000, 32'hFFFF_FFFF));
        run_cycle(0, 1'b1, 2'b10, 2'b10, 32'h0, 32'hCAFE_F00D, 1'b1, 3,
                  mk(2'b00, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4'b0011, 2, 0, 32'h0, 32'h0));
        run_cycle(0, 1'b1, 2'b01, 2'b10, 32'h0, 32'h1357_9BDF, 1'b1, 3,
                  mk(2'b00, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b0000, 0, 0, 32'h0, 32'h0));
        run_cycle(0, 1'b0, 2'b00, 2'b11, 32'h1122_3344, 32'h0, 1'b1, 3,
                  mk(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 4'b1111, 0, 2, 32'h1122_3344, 32'hFFFF_FFFF));
        run_cycle(0, 1'b0, 2'b11, 2'b10, 32'h5555_5555, 32'h0, 1'b1, 3,
                  mk(2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000, 0, 0, 32'h0, 32'h0));

        // 16-bit port: long then the initiator's word retry at A=10.
        run_cycle(1, 1'b1, 2'b00, 2'b00, 32'h0, 32'hAAAA_BBBB, 1'b1, 3,
                  mk(2'b01, 1'b1, 32'hAAAA_FFFF, 1'b1, 1'b0, 4'b1100, 2, 0, 32'h0, 32'h0));
        run_cycle(1, 1'b1, 2'b10, 2'b10, 32'h0, 32'hAAAA_BBBB, 1'b1, 3,
                  mk(2'b01, 1'b1, 32'hBBBB_FFFF, 1'b1, 1'b0, 4'b0011, 2, 0, 32'h0, 32'h0));
        run_cycle(1, 1'b0, 2'b10, 2'b10, 32'h5A5A_0000, 32'h0, 1'b1, 3,
                  mk(2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0011, 0, 2, 32'h0000_5A5A, 32'h0000_FFFF));
        run_cycle(1, 1'b0, 2'b01, 2'b01, 32'h0077_0000, 32'h0, 1'b1, 3,
                  mk(2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 0, 2, 32'h0077_0000, 32'h00FF_0000));

        // N=1 port: normal read at k+2, then timeout with READY stuck low at k+6.
        run_cycle(2, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0BAD_C0DE, 1'b1, 2,
                  mk(2'b00, 1'b1, 32'h0BAD_C0DE, 1'b1, 1'b0, 4'b1111, 1, 0, 32'h0, 32'h0));
        run_cycle(2, 1'b1, 2'b00, 2'b00, 32'h0, 32'h8765_4321, 1'b0, 6,
                  mk(2'b00, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b1111, 5, 0, 32'h0, 32'h0));

        // nTS held during WAIT, ACK and RECOVER, then nTS with no DEV_SEL.
        rnw = 1'b1; a = 2'b00; siz = 2'b00; dev_rdata = 32'h0F0F_0F0F; dev_ready = 1'b1;
        dev_sel = 3'b001; n_ts = 1'b0;
        sb_q[0].push_back(mk(2'b00, 1'b1, 32'h0F0F_0F0F, 1'b1, 1'b0, 4'b1111, 2, 0, 32'h0, 32'h0));
        sb_q[0][sb_q[0].size() - 1].ack_cyc = cyc + 4;
        pushed[0]++;
        target = done[0] + 1;
        @(posedge clk); #1;
        @(posedge clk); #1; n_ts = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; n_ts = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; n_ts = 1'b1; dev_sel = 3'b000;
        @(posedge clk); #1; n_ts = 1'b0;
        @(posedge clk); #1; n_ts = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("ignored_nts_one_ack", done[0], target);

        // Reset while in WAIT aborts the cycle without ACK.
        rnw = 1'b1; a = 2'b00; siz = 2'b00; dev_rdata = 32'h7777_7777;
        dev_sel = 3'b001; n_ts = 1'b0;
        target = done[0];
        @(posedge clk); #1;
        n_ts = 1'b1; dev_sel = 3'b000; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_dsack",  {30'd0, dsack[0]}, 32'd3);
        check("midrst_dev_rd", {31'd0, dev_rd[0]}, 32'd0);
        check("midrst_d_oe",   {31'd0, d_oe[0]}, 32'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_ack", done[0], target);
        run_cycle(0, 1'b1, 2'b00, 2'b10, 32'h0, 32'h89AB_CDEF, 1'b1, 3,
                  mk(2'b00, 1'b1, 32'h89AB_CDEF, 1'b1, 1'b0, 4'b1100, 2, 0, 32'h0, 32'h0));

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("du%0d_sb_drained", i), sb_q[i].size(), 0);
            check($sformatf("du%0d_oe_outside_ack", i), oe_viol[i], 0);
        end
        check("du0_terr_pulses", terr_seen[0], 0);
        check("du1_terr_pulses", terr_seen[1], 0);
        check("du2_terr_pulses", terr_seen[2], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/amiga_port_responder.md
Name: amiga_port_responder

Overview:
- Bus target that answers transfers issued by the 68040 card's dynamic bus sizing logic on the AmigaPCI side.
- Samples nTS/SIZ/A/RnW and runs a wait-state-counted access to a local 32-bit device interface.
- Returns DSACK with the configured port width (32 or 16 bit) and steers byte lanes so a 16-bit port pairs correctly with the initiator's word-retry behaviour.

Parameters:
- PORT_WIDTH, 32, port width reported on DSACK; legal values 32 or 16.
- WAIT_STATES, 2, minimum clocks in WAIT before ACK; legal range 1..15.
- TIMEOUT, 255, clocks DEV_READY may stay low after wait states expire; 8-bit.

Ports:
- CLK40 input 1: bus clock; all logic on rising edge.
- RESET input 1: synchronous, active-high reset.
- nTS input 1: transfer start, active low, one-clock pulse.
- RnW input 1: 1 = read, 0 = write.
- A input 2: address bits 1:0.
- SIZ input 2: transfer size. 00 long, 01 byte, 10 word, 11 burst (treated as long).
- DEV_SEL input 1: external address decode hit, valid with nTS.
- D_IN input 32: bus write data. D_IN[31:24] is the byte at A=00 (MSB).
- D_OUT output 32: bus read data, same lane order as D_IN.
- D_OE output 1: enable for the D_OUT drivers.
- DSACK output 2: active-low termination. 00 long, 01 word, 11 wait.
- DEV_RD output 1: device read strobe.
- DEV_WR output 1: device write strobe.
- DEV_BE output 4: device byte enables. Bit 3 = MSB lane.
- DEV_WDATA output 32: device write data.
- DEV_RDATA input 32: device read data.
- DEV_READY input 1: device completion.
- TIMEOUT_ERR output 1: one-clock pulse when a cycle ends by timeout.

Behaviour:
- Reset values (RESET high at an edge):
  - state IDLE, DSACK=11, D_OE=0, DEV_RD=0, DEV_WR=0, TIMEOUT_ERR=0.
  - DEV_BE=0000, DEV_WDATA=0, D_OUT=FFFFFFFF.
  - Reset mid-cycle aborts with no ACK.
- States: IDLE -> WAIT -> ACK -> RECOVER -> IDLE.
- IDLE:
  - At an edge with nTS=0 and DEV_SEL=1: latch RnW, A, SIZ; load wait counter with WAIT_STATES; load timeout counter with TIMEOUT; go to WAIT.
  - nTS=0 with DEV_SEL=0 is ignored.
- Byte enables:
  - Byte: A 00/01/10/11 -> 1000/0100/0010/0001.
  - Word: A=00 -> 1100, A=10 -> 0011.
  - Long or burst: 1111.
  - Misaligned word (A[0]=1): DEV_BE=0000; no strobe; cycle still ACKs, reads return FFFFFFFF.
- PORT_WIDTH=16:
  - Long or burst: DEV_BE=1100 only; ACK=01, so the initiator reruns the cycle at A=10.
  - A[1]=1 cycles use the upper bus lanes: write D_IN[31:16] -> DEV_WDATA[15:0]; read DEV_RDATA[15:0] -> D_OUT[31:16].
  - D_OUT[15:0] = FFFF.
- PORT_WIDTH=32: natural lanes; ACK=00 for every cycle.
- WAIT state:
  - DEV_RD=RnW and DEV_WR=!RnW (gated by non-zero DEV_BE).
  - DEV_WDATA captured at the first WAIT edge, i.e. one edge after nTS, then held until the cycle ends.
  - Wait counter non-zero: decrement.
  - Wait counter zero and DEV_READY=1: capture D_OUT (mapped DEV_RDATA) and go to ACK.
  - Wait counter zero and DEV_READY=0: decrement the timeout counter. At zero: D_OUT=FFFFFFFF, pulse TIMEOUT_ERR, go to ACK.
- ACK (one clock):
  - DSACK = 01 (16-bit) or 00 (32-bit); D_OE=RnW; strobes low.
- RECOVER (one clock): DSACK=11, D_OE=0. nTS sampled here or in ACK is ignored.
- Latency: WAIT_STATES=N with DEV_READY held high -> nTS sampled at edge k, DSACK asserted from edge k+N+1 to edge k+N+2.

Test Plan:
- 32-bit port, N=2: long read at A=00, DEV_RDATA=12345678, READY=1 -> DSACK=00 for exactly one clock from edge k+3; D_OUT=12345678; D_OE=1 only in that clock.
- 32-bit port: byte write at A=01, D_IN=00AB0000 -> DEV_BE=0100, DEV_WR high for 2 clocks, DEV_WDATA=00AB0000, DSACK=00.
- 16-bit port: long read A=00, then rerun word read A=10 with DEV_RDATA=AAAABBBB -> first cycle DSACK=01 with D_OUT[31:16]=AAAA; second cycle DEV_BE=0011, DSACK=01, D_OUT[31:16]=BBBB.
- N=1, TIMEOUT=4, DEV_READY stuck low on a read -> DSACK asserted at edge k+6, D_OUT=FFFFFFFF, TIMEOUT_ERR pulses once.
- Second nTS during WAIT and during ACK, and nTS with DEV_SEL=0 -> ignored; exactly one DSACK per accepted cycle.
- RESET asserted mid-WAIT -> next clock DSACK=11, strobes low, D_OE=0; a fresh nTS after reset completes normally.
